// File: rtl/mod_n_down_counter.sv
// Synchronous modulo-MOD down counter with parallel load, count enable and a
// one-shot mode that parks in a HALT state at zero. Y, WRAP and DONE are registered.
module mod_n_down_counter #(
  parameter int WIDTH = 2,
  parameter int MOD   = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             ONESHOT,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO,
  output logic             WRAP,
  output logic             DONE
);

  typedef enum logic {
    COUNT = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TOP_VALUE = WIDTH'(MOD - 1);
  // The clamp compare is one bit wider so a modulus of 2^WIDTH still fits.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH-1:0] load_value;
  logic             count_is_zero;

  assign d_ext         = {1'b0, D};
  assign load_value    = (d_ext >= MOD_EXT) ? TOP_VALUE : D;
  assign count_is_zero = (count_reg == '0);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg <= COUNT;
      count_reg <= TOP_VALUE;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (LOAD) begin
      count_next = load_value;
      state_next = COUNT;
    end else begin
      case (state_reg)
        COUNT: begin
          if (EN) begin
            if (!count_is_zero) begin
              count_next = count_reg - WIDTH'(1);
            end else if (!ONESHOT) begin
              count_next = TOP_VALUE;
              wrap_next  = 1'b1;
            end else begin
              state_next = HALT;
            end
          end
        end
        HALT: begin
          // Parked at zero; only LOAD or reset gets out.
          count_next = '0;
        end
        default: begin
          state_next = COUNT;
          count_next = TOP_VALUE;
        end
      endcase
    end
  end

  assign Y    = count_reg;
  assign ZERO = count_is_zero;
  assign WRAP = wrap_reg;
  assign DONE = (state_reg == HALT);

endmodule
